// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for a combinational N-bit ALU: queues register-addressed
// instructions, feeds operands from a local register file, and writes results back.
module alu_sequencer #(
  parameter int N     = 8,
  parameter int REGS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [$clog2(REGS)-1:0] in_rd,
  input  logic [$clog2(REGS)-1:0] in_rs1,
  input  logic [$clog2(REGS)-1:0] in_rs2,
  input  logic [N-1:0]            in_imm,
  input  logic                    in_signed,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [3:0]              alu_operation,
  output logic                    alu_signed,
  input  logic [N-1:0]            alu_result,
  output logic                    done_valid,
  output logic [$clog2(REGS)-1:0] done_rd,
  output logic [N-1:0]            done_data,
  output logic                    done_err,
  input  logic [$clog2(REGS)-1:0] dbg_addr,
  output logic [N-1:0]            dbg_data
);

  localparam int AW = $clog2(REGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_LOADI = 4'hF;

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [N-1:0]  imm;
    logic          sgn;
  } instr_t;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t        state_q, state_d;
  instr_t        fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  instr_t        ir;
  logic [N-1:0]  regs [REGS];

  logic          push, pop, err;
  logic [N-1:0]  rs2_val, result;

  // in_ready looks only at the registered count, so a full FIFO refuses a push
  // even when the head is popped on the same edge.
  assign in_ready = rst_n && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count != '0);

  // NOTE: storage entries carry no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                                   imm: in_imm, sgn: in_signed};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rs2_val = regs[ir.rs2];
  assign err     = (ir.op inside {[4'd9:4'd14]}) || ((ir.op == OP_DIV) && (rs2_val == '0));
  assign result  = (ir.op == OP_LOADI) ? ir.imm : alu_result;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = '0;
    alu_signed    = 1'b0;
    if (state_q == EXEC) begin
      alu_a         = regs[ir.rs1];
      alu_b         = rs2_val;
      alu_operation = ir.op;
      alu_signed    = ir.sgn;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir        <= '0;
      done_rd   <= '0;
      done_data <= '0;
      done_err  <= 1'b0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      if (pop) ir <= fifo_mem[rd_ptr];
      if (state_q == EXEC) begin
        if (!err) regs[ir.rd] <= result;
        done_rd   <= ir.rd;
        done_data <= err ? '0 : result;
        done_err  <= err;
      end
    end
  end

  assign done_valid = (state_q == WB);
  assign dbg_data   = regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, register model and an
// in-order scoreboard of expected completions.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_signed;
  logic [3:0] in_op, alu_operation;
  logic [1:0] in_rd, in_rs1, in_rs2, done_rd, dbg_addr;
  logic [7:0] in_imm, alu_a, alu_b, alu_result, done_data, dbg_data;
  logic       alu_signed, done_valid, done_err;

  alu_sequencer #(.N(8), .REGS(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_signed(in_signed), .alu_a(alu_a), .alu_b(alu_b),
    .alu_operation(alu_operation), .alu_signed(alu_signed), .alu_result(alu_result),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .done_err(done_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic sgn);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return (b == 0) ? 8'h00 : (sgn ? 8'($signed(a) / $signed(b)) : a / b);
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return ~a;
      4'd7: return a << b[2:0];
      4'd8: return sgn ? 8'($signed(a) >>> b[2:0]) : a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_operation, alu_a, alu_b, alu_signed);

  typedef struct {
    logic [1:0] rd;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         done_cyc_q[$];
  logic [7:0] mreg [4];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: every done pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && done_valid) begin
      done_count++;
      done_cyc_q.push_back(cyc);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got rd=%0d data=%h err=%0d, expected no pulse",
                 done_rd, done_data, done_err);
      end else begin
        mon_e = sb.pop_front();
        if ({done_rd, done_data, done_err} !== {mon_e.rd, mon_e.data, mon_e.err}) begin
          fails++;
          $display("FAIL done_result: got rd=%0d data=%h err=%0d, expected rd=%0d data=%h err=%0d",
                   done_rd, done_data, done_err, mon_e.rd, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic model_push(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic [7:0] imm, input logic sgn);
    exp_t e;
    e.rd = rd;
    e.err = 1'b0;
    if (op == 4'hF) e.data = imm;
    else if (op > 4'd8 || (op == 4'd3 && mreg[rs2] == 8'h00)) begin
      e.err = 1'b1;
      e.data = 8'h00;
    end else e.data = alu_ref(op, mreg[rs1], mreg[rs2], sgn);
    if (!e.err) mreg[rd] = e.data;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] imm, input bit expect_done,
                      output int acc_cyc);
    int waits = 0;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_signed = 1'b0;
    in_valid = 1'b1;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
      in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    if (expect_done) model_push(op, rd, rs1, rs2, imm, 1'b0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d completions outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic read_dbg(input logic [1:0] addr, output logic [7:0] val);
    @(negedge clk);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({in_ready, done_valid, alu_operation, alu_a} !== 14'b0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%0d done=%0d op=%h a=%h, expected all 0",
               in_ready, done_valid, alu_operation, alu_a);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %0d, expected 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      read_dbg(2'(i), v);
      tests++;
      if (v !== 8'h00) begin
        fails++;
        $display("FAIL reset_reg%0d: got %h, expected 00", i, v);
      end
    end
  endtask

  task automatic test_chain();
    int a0, a1, a2;
    logic [7:0] v;
    done_cyc_q.delete();
    send(4'hF, 2'd1, 2'd0, 2'd0, 8'h0F, 1'b1, a0);
    send(4'hF, 2'd2, 2'd0, 2'd0, 8'h03, 1'b1, a1);
    send(4'd0, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, a2);
    wait_drain();
    tests++;
    if (done_cyc_q.size() != 3) begin
      fails++;
      $display("FAIL chain_pulses: got %0d pulses, expected 3", done_cyc_q.size());
    end else begin
      tests++;
      if (done_cyc_q[0] - a0 != 2 || done_cyc_q[1] - done_cyc_q[0] != 3 ||
          done_cyc_q[2] - done_cyc_q[1] != 3) begin
        fails++;
        $display("FAIL chain_timing: got latency %0d spacing %0d,%0d, expected 2 and 3,3",
                 done_cyc_q[0] - a0, done_cyc_q[1] - done_cyc_q[0], done_cyc_q[2] - done_cyc_q[1]);
      end
    end
    read_dbg(2'd3, v);
    tests++;
    if (v !== 8'h12) begin
      fails++;
      $display("FAIL chain_dbg_r3: got %h, expected 12", v);
    end
  endtask

  task automatic test_wrap();
    int a;
    logic [7:0] v;
    send(4'd1, 2'd0, 2'd2, 2'd1, 8'h00, 1'b1, a);
    wait_drain();
    read_dbg(2'd0, v);
    tests++;
    if (v !== 8'hF4) begin
      fails++;
      $display("FAIL wrap_sub: got %h, expected F4", v);
    end
    send(4'd2, 2'd0, 2'd1, 2'd1, 8'h00, 1'b1, a);
    wait_drain();
    read_dbg(2'd0, v);
    tests++;
    if (v !== 8'hE1) begin
      fails++;
      $display("FAIL wrap_mul: got %h, expected E1", v);
    end
  endtask

  task automatic test_fault();
    int a;
    logic [7:0] v;
    send(4'hF, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, a);
    send(4'd3, 2'd3, 2'd1, 2'd0, 8'h00, 1'b1, a);
    send(4'hA, 2'd2, 2'd1, 2'd1, 8'h00, 1'b1, a);
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      read_dbg(2'(i), v);
      tests++;
      if (v !== mreg[i]) begin
        fails++;
        $display("FAIL fault_reg%0d: got %h, expected %h", i, v, mreg[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bit saw_low = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op = 4'hF; in_rd = acc[1:0]; in_rs1 = 2'd0; in_rs2 = 2'd0;
      in_imm = 8'h40 + 8'(acc); in_signed = 1'b0;
      if (in_ready) begin
        model_push(4'hF, acc[1:0], 2'd0, 2'd0, 8'h40 + 8'(acc), 1'b0);
        acc++;
      end else saw_low = 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (acc != 9 || !saw_low) begin
      fails++;
      $display("FAIL backpressure_accepts: got %0d accepts low_seen=%0d, expected 9 and 1",
               acc, saw_low);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int a, snap;
    logic [7:0] v;
    send(4'hF, 2'd1, 2'd0, 2'd0, 8'h55, 1'b1, a);
    send(4'hF, 2'd2, 2'd0, 2'd0, 8'h66, 1'b0, a);
    send(4'hF, 2'd3, 2'd0, 2'd0, 8'h67, 1'b0, a);
    send(4'hF, 2'd0, 2'd0, 2'd0, 8'h68, 1'b0, a);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (alu_operation !== 4'hF) begin
      fails++;
      $display("FAIL midreset_exec: got alu_operation=%h, expected F", alu_operation);
    end
    snap = done_count;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_ready_low: got %0d, expected 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    repeat (10) @(negedge clk);
    tests++;
    if (done_count != snap || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_quiet: got %0d pulses ready=%0d, expected 0 pulses ready=1",
               done_count - snap, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      read_dbg(2'(i), v);
      tests++;
      if (v !== 8'h00) begin
        fails++;
        $display("FAIL midreset_reg%0d: got %h, expected 00", i, v);
      end
    end
    send(4'hF, 2'd2, 2'd0, 2'd0, 8'h77, 1'b1, a);
    wait_drain();
    read_dbg(2'd2, v);
    tests++;
    if (v !== 8'h77) begin
      fails++;
      $display("FAIL midreset_new_loadi: got %h, expected 77", v);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_signed = 1'b0; dbg_addr = '0;
    test_reset();
    test_chain();
    test_wrap();
    test_fault();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue and writeback stage wrapped around the combinational N-bit ALU (ops 0-8: add, sub, mul, div, and, or, not, shl, shr; plus signed flag).
- Accepts register-addressed instructions through a valid/ready handshake into a small FIFO.
- Reads operands from a local register file and drives the ALU operand, operation and signed ports.
- Captures the ALU result, writes it back to the register file, and reports completion.
- Sits directly upstream of the ALU and consumes its result.

Parameters:
N, 8, datapath width; must match the ALU N.
REGS, 4, register-file entries; power of 2, at least 2. AW = $clog2(REGS).
DEPTH, 4, instruction FIFO entries; power of 2, at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  instruction present.
in_ready  output  1  FIFO can accept this cycle.
in_op  input  4  ALU operation 0-8; 4'hF = LOADI; 9-14 illegal.
in_rd  input  AW  destination register.
in_rs1  input  AW  source A register.
in_rs2  input  AW  source B register.
in_imm  input  N  immediate; used by LOADI only.
in_signed  input  1  passed to the ALU signed port.
alu_a  output  N  ALU operand a.
alu_b  output  N  ALU operand b.
alu_operation  output  4  ALU operation.
alu_signed  output  1  ALU signed.
alu_result  input  N  ALU result (combinational).
done_valid  output  1  one-cycle completion pulse.
done_rd  output  AW  completed destination register.
done_data  output  N  written or would-be value.
done_err  output  1  instruction faulted; no write occurred.
dbg_addr  input  AW  debug register-file read address.
dbg_data  output  N  combinational reg[dbg_addr].

Behaviour:
- Reset (rst_n=0 at an edge):
  - FIFO emptied; FSM to IDLE.
  - All registers cleared to 0.
  - done_valid, done_rd, done_data and done_err set to 0.
  - The in-flight instruction is dropped with no write and no done pulse.
  - in_ready is 0 while rst_n=0.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (count < DEPTH), computed from the registered count only.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Instructions complete strictly in FIFO order.
- FSM states: IDLE, EXEC, WB.
  - IDLE: if FIFO is non-empty, pop the head into the instruction register and go to EXEC; otherwise stay.
  - EXEC:
    - alu_a = reg[rs1], alu_b = reg[rs2], alu_operation = op, alu_signed = signed.
    - At the edge, compute the result: alu_result for ops 0-8, imm for LOADI.
    - err = 1 if the op is illegal (9-14), or if op = 3 and reg[rs2] == 0.
    - If err = 0, write reg[rd] at this edge.
    - Register done_rd, done_data and done_err at this edge.
    - Go to WB.
  - WB: done_valid = 1 for exactly this cycle, and reg[rd] already shows the new value. Then go to IDLE.
- When not in EXEC, alu_a, alu_b, alu_operation and alu_signed are driven to 0.
- done_* hold their last value after the pulse; the bench samples them only while done_valid = 1.
- Latency: an instruction accepted at edge k into an empty FIFO with FSM in IDLE:
  - popped at edge k+1;
  - written at edge k+2;
  - done_valid high in the cycle after edge k+2.
- Throughput: 1 instruction per 3 cycles.
- Hazards: none. An instruction reads registers only after its predecessor's write has completed; rd == rs1/rs2 is legal and reads the old value.
- Width: results are taken as the ALU's N-bit result, so add/sub/mul wrap modulo 2^N.
- done_data on error is 0.
- dbg_data is combinational and reflects writes from the cycle after the write edge.

Test Plan:
- Arithmetic chain: LOADI r1=0x0F, LOADI r2=0x03, then ADD r3=r1+r2 -> three done pulses 3 cycles apart, the last with done_rd=3, done_data=0x12, done_err=0; dbg r3=0x12.
- Unsigned wrap: with r1=0x0F, r2=0x03, SUB r0=r2-r1 -> done_data=0xF4; MUL r0=r1*r1 -> done_data=0xE1.
- Fault handling:
  - DIV r3=r1/r0 with r0=0 -> done_err=1, done_data=0, r3 unchanged.
  - Illegal op 4'hA -> done_err=1, no register changes.
- Backpressure: hold in_valid=1 for 16 cycles with distinct LOADIs -> in_ready falls when count==4, never more than 4 queued; done pulses equal accepted pushes, in order, with correct rd/data.
- Reset mid-operation: assert rst_n=0 for one edge while in EXEC with 2 queued -> no done pulse; all registers 0; in_ready=1 after release; a new LOADI completes normally.
